imx415_cfg_seq: RTL and testbench
=================================

# imx415_cfg_seq

Sequencer that brings up the IMX415 sensor over I2C after power-up. It walks the combinational IMX415 register LUT, which supplies a 16-bit address and 8-bit data per index. Each entry is issued as one write transaction to the shared I2C byte master. After the table it releases standby (0x3000←0x00), waits for the sensor to stabilise, then starts master streaming (0x3002←0x00). It sits between the system reset/start logic and the I2C master, ahead of the MIPI receive path.

## Interface
- DEV_ADDR, 7'h1A: sensor 7-bit I2C slave address.
- PWRUP_DLY, 32'd2_500_000: clock cycles to wait after start before the first write.
- STBY_DLY, 32'd625_000: clock cycles between the standby-release write and the XMSTA write.
- MAX_RETRY, 3: NACK retries per entry (used only with the macro below).
- I_clk  in  1  system clock; all logic on rising edge.
- I_rst  in  1  synchronous, active-high reset.
- I_start  in  1  one-cycle pulse; begins or restarts the full sequence.
- O_reg_index  out  9  LUT index.
- I_reg_data  in  32  LUT data; [23:8] = register address, [7:0] = value; [31:24] ignored.
- I_reg_size  in  8  number of LUT entries.
- O_iic_req  out  1  one-cycle write request to the I2C master.
- O_iic_dev  out  7  constant DEV_ADDR.
- O_iic_addr  out  16  register address.
- O_iic_wdata  out  8  register value.
- I_iic_busy  in  1  master busy.
- I_iic_done  in  1  one-cycle transaction complete.
- I_iic_nack  in  1  valid with I_iic_done; 1 = slave NACK.
- O_busy  out  1  sequence in progress.
- O_cfg_done  out  1  level; sensor configured and streaming.
- O_cfg_err  out  1  level; sequence aborted on NACK.

## Operation
- States: IDLE, PWRUP, FETCH, ISSUE, WAIT, NEXT, STBY_WR, STBY_WAIT, XMSTA_WR, DONE, ERR.
- IDLE: index=0. I_start → PWRUP, load counter with PWRUP_DLY.
- PWRUP: count down to 0 → FETCH.
- FETCH (1 cycle): latch I_reg_data[23:8] into O_iic_addr and [7:0] into O_iic_wdata → ISSUE.
- ISSUE: when I_iic_busy=0, pulse O_iic_req for 1 cycle → WAIT. If busy=1, hold in ISSUE.
- WAIT: on I_iic_done with nack=0 → NEXT. On I_iic_done with nack=1 → ERR, or a retry (see Configuration).
- NEXT: if index==I_reg_size-1 → STBY_WR. Otherwise index+1 → FETCH. The index comparison is 9-bit against zero-extended I_reg_size. I_reg_size=0 skips the table and goes straight to STBY_WR.
- STBY_WR: addr=16'h3000, data=8'h00. Uses the same ISSUE/WAIT handshake, then → STBY_WAIT with counter loaded to STBY_DLY.
- STBY_WAIT: counter reaches 0 → XMSTA_WR.
- XMSTA_WR: addr=16'h3002, data=8'h00. Same handshake, then → DONE.
- DONE: O_cfg_done=1. ERR: O_cfg_err=1. Both states hold until I_start, which clears the flags and → PWRUP.
- I_start while O_busy=1 is ignored.
- O_iic_addr and O_iic_wdata stay stable from FETCH through I_iic_done.

## Timing
- Reset values: O_reg_index=0, O_iic_req=0, O_iic_addr=0, O_iic_wdata=0, O_busy=0, O_cfg_done=0, O_cfg_err=0, state=IDLE. O_iic_dev is constant.
- I_rst mid-transaction returns to IDLE next cycle. Any outstanding I_iic_done is ignored in IDLE.
- O_busy=1 in every state except IDLE, DONE and ERR; it rises the cycle after I_start.
- Per-entry overhead with an idle master: FETCH 1 + ISSUE 1 + master latency + NEXT 1 cycle.
- I_iic_done arriving in the same cycle as O_iic_req is not allowed. The master must signal done at least 1 cycle after the request.
- A delay counter loaded with N takes N cycles to reach 0. N=0 advances on the next cycle.
- An I_iic_done seen outside WAIT is ignored.

## Configuration
- IMX415_CFG_RETRY_EN defined: on NACK, re-enter ISSUE with the same address and data and increment a per-entry retry counter. The counter clears on every FETCH and on the standby/XMSTA writes. The (MAX_RETRY+1)-th consecutive NACK → ERR.
- IMX415_CFG_RETRY_EN undefined: the first NACK → ERR. MAX_RETRY is unused.

## Test plan
- Start with I_reg_size=201, master model acks every write, PWRUP_DLY=10, STBY_DLY=20 → exactly 203 requests; write #0 is 3000←01, #200 is 4074←01, then 3000←00, then ≥20 cycles later 3002←00; O_cfg_done=1 and O_busy=0.
- Master holds I_iic_busy=1 for 50 cycles during ISSUE → no O_iic_req during busy; exactly one req in the cycle after busy falls; addr/data unchanged.
- NACK on index 5 (0x3009) with the macro undefined → ERR, O_cfg_err=1, index stays 5, no further reqs. With the macro defined and MAX_RETRY=3: 2 NACKs then ack → 3 reqs to 0x3009 and completion; 4 NACKs → ERR.
- I_rst asserted during WAIT at index 100 → next cycle all outputs at reset values; a subsequent I_start restarts at index 0 after PWRUP_DLY.
- I_reg_size=0 → only the 3000←00 and 3002←00 writes are issued, then DONE.
- I_start pulse during PWRUP and during WAIT → ignored; the sequence completes normally with 203 writes.

Source files
------------

// File: rtl/imx415_cfg_seq.sv
// IMX415 power-up sequencer: walks the register LUT over the I2C byte master, then releases standby and starts streaming.
// Define IMX415_CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY times before aborting.
module imx415_cfg_seq #(
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter logic [31:0] PWRUP_DLY = 32'd2_500_000,
  parameter logic [31:0] STBY_DLY  = 32'd625_000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_start,
  output logic [8:0]  O_reg_index,
  input  logic [31:0] I_reg_data,
  input  logic [7:0]  I_reg_size,
  output logic        O_iic_req,
  output logic [6:0]  O_iic_dev,
  output logic [15:0] O_iic_addr,
  output logic [7:0]  O_iic_wdata,
  input  logic        I_iic_busy,
  input  logic        I_iic_done,
  input  logic        I_iic_nack,
  output logic        O_busy,
  output logic        O_cfg_done,
  output logic        O_cfg_err
);

  typedef enum logic [3:0] {
    IDLE, PWRUP, FETCH, ISSUE, WAIT, NEXT, STBY_WR, STBY_WAIT, XMSTA_WR, DONE, ERR
  } state_e;

  // Which write the shared ISSUE/WAIT handshake is currently serving.
  typedef enum logic [1:0] {PH_TABLE, PH_STBY, PH_XMSTA} phase_e;

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

`ifdef IMX415_CFG_RETRY_EN
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
`else
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = '0;
`endif

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [8:0]         index_q, index_d;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               req_q, req_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [8:0]         last_index;
  logic               unused_reg_hi;

  assign last_index    = {1'b0, I_reg_size} - 9'd1;
  assign unused_reg_hi = ^I_reg_data[31:24];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      phase_q <= PH_TABLE;
      cnt_q   <= '0;
      index_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin : next_state
    // NOTE: every _d gets a hold default first so no branch can infer a latch.
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = 1'b0;
    retry_d = retry_q;
    unique case (state_q)
      IDLE: begin
        index_d = '0;
        if (I_start) begin
          state_d = PWRUP;
          cnt_d   = PWRUP_DLY;
        end
      end
      PWRUP: begin
        if (cnt_q == '0) state_d = (I_reg_size == 8'd0) ? STBY_WR : FETCH;
        else             cnt_d   = cnt_q - 32'd1;
      end
      FETCH: begin
        addr_d  = I_reg_data[23:8];
        wdata_d = I_reg_data[7:0];
        phase_d = PH_TABLE;
        retry_d = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (!I_iic_busy) begin
          req_d   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (I_iic_done) begin
          if (I_iic_nack) begin
            if (retry_q == RETRY_LIMIT) begin
              state_d = ERR;
            end else begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ISSUE;
            end
          end else begin
            unique case (phase_q)
              PH_TABLE: state_d = NEXT;
              PH_STBY: begin
                state_d = STBY_WAIT;
                cnt_d   = STBY_DLY;
              end
              default:  state_d = DONE;
            endcase
          end
        end
      end
      NEXT: begin
        if (index_q == last_index) begin
          state_d = STBY_WR;
        end else begin
          index_d = index_q + 9'd1;
          state_d = FETCH;
        end
      end
      STBY_WR: begin
        addr_d  = 16'h3000;
        wdata_d = 8'h00;
        phase_d = PH_STBY;
        retry_d = '0;
        state_d = ISSUE;
      end
      STBY_WAIT: begin
        if (cnt_q == '0) state_d = XMSTA_WR;
        else             cnt_d   = cnt_q - 32'd1;
      end
      XMSTA_WR: begin
        addr_d  = 16'h3002;
        wdata_d = 8'h00;
        phase_d = PH_XMSTA;
        retry_d = '0;
        state_d = ISSUE;
      end
      DONE, ERR: begin
        if (I_start) begin
          index_d = '0;
          state_d = PWRUP;
          cnt_d   = PWRUP_DLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    O_busy     = 1'b1;
    O_cfg_done = 1'b0;
    O_cfg_err  = 1'b0;
    unique case (state_q)
      IDLE:    O_busy = 1'b0;
      DONE: begin
        O_busy     = 1'b0;
        O_cfg_done = 1'b1;
      end
      ERR: begin
        O_busy    = 1'b0;
        O_cfg_err = 1'b1;
      end
      default: O_busy = 1'b1;
    endcase
  end

  assign O_reg_index = index_q;
  assign O_iic_req   = req_q;
  assign O_iic_dev   = DEV_ADDR;
  assign O_iic_addr  = addr_q;
  assign O_iic_wdata = wdata_q;

endmodule

// File: tb/tb_imx415_cfg_seq.sv
// Self-checking bench for imx415_cfg_seq: random LUT and master latency, expected write list built from the sequence rules.
module tb_imx415_cfg_seq;

  localparam logic [31:0] PWRUP_DLY = 32'd10;
  localparam logic [31:0] STBY_DLY  = 32'd20;
  localparam int          MAX_RETRY = 3;
`ifdef IMX415_CFG_RETRY_EN
  localparam int          TB_RETRIES = MAX_RETRY;
`else
  localparam int          TB_RETRIES = 0;
`endif
  localparam logic [15:0] NACK_ADDR = 16'h3009;
  localparam int          BUDGET    = 20000;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_start = 1'b0;
  logic [8:0]  O_reg_index;
  logic [31:0] I_reg_data;
  logic [7:0]  I_reg_size = 8'd0;
  logic        O_iic_req;
  logic [6:0]  O_iic_dev;
  logic [15:0] O_iic_addr;
  logic [7:0]  O_iic_wdata;
  logic        I_iic_busy;
  logic        I_iic_done = 1'b0;
  logic        I_iic_nack = 1'b0;
  logic        O_busy;
  logic        O_cfg_done;
  logic        O_cfg_err;

  logic [31:0] lut [0:511];
  logic [23:0] obs_q[$];
  int          obs_cyc[$];
  logic [23:0] exp_q[$];
  bit          exp_err;
  int          exp_idx;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int start_cyc = 0;

  logic mst_busy   = 1'b0;
  logic mst_nack   = 1'b0;
  logic force_busy = 1'b0;
  int   mst_cnt    = 0;
  int   fixed_lat  = 0;
  int   nack_left  = 0;

  imx415_cfg_seq #(
    .DEV_ADDR (7'h1A),
    .PWRUP_DLY(PWRUP_DLY),
    .STBY_DLY (STBY_DLY),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .I_start    (I_start),
    .O_reg_index(O_reg_index),
    .I_reg_data (I_reg_data),
    .I_reg_size (I_reg_size),
    .O_iic_req  (O_iic_req),
    .O_iic_dev  (O_iic_dev),
    .O_iic_addr (O_iic_addr),
    .O_iic_wdata(O_iic_wdata),
    .I_iic_busy (I_iic_busy),
    .I_iic_done (I_iic_done),
    .I_iic_nack (I_iic_nack),
    .O_busy     (O_busy),
    .O_cfg_done (O_cfg_done),
    .O_cfg_err  (O_cfg_err)
  );

  always #5 I_clk = ~I_clk;
  always @(posedge I_clk) cyc <= cyc + 1;

  assign I_reg_data = lut[O_reg_index];
  assign I_iic_busy = mst_busy || force_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // I2C master model: logs each request, answers after 1..4 cycles, NACKs NACK_ADDR while nack_left > 0.
  always @(negedge I_clk) begin
    I_iic_done = 1'b0;
    I_iic_nack = 1'b0;
    if (mst_cnt > 0) begin
      mst_cnt--;
      if (mst_cnt == 0) begin
        I_iic_done = 1'b1;
        I_iic_nack = mst_nack;
        mst_busy   = 1'b0;
        if (O_busy && obs_q.size() > 0)
          check("wr_stable", {8'h0, O_iic_addr, O_iic_wdata}, {8'h0, obs_q[obs_q.size()-1]});
      end
    end
    if (O_iic_req) begin
      obs_q.push_back({O_iic_addr, O_iic_wdata});
      obs_cyc.push_back(cyc);
      mst_nack = (nack_left > 0) && (O_iic_addr == NACK_ADDR);
      if (mst_nack) nack_left--;
      mst_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      mst_busy = 1'b1;
    end
  end

  // Expected write list: each table entry once, the NACKed entry once per attempt, then standby and XMSTA.
  function automatic void build_exp(input int size, input int nacks);
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = 0;
    for (int i = 0; i < size; i++) begin
      int tries = 1;
      if (lut[i][23:8] == NACK_ADDR) tries = (nacks > TB_RETRIES) ? TB_RETRIES + 1 : nacks + 1;
      for (int t = 0; t < tries; t++) exp_q.push_back(lut[i][23:0]);
      if (lut[i][23:8] == NACK_ADDR && nacks > TB_RETRIES) begin
        exp_err = 1'b1;
        exp_idx = i;
        return;
      end
    end
    exp_q.push_back(24'h3000_00);
    exp_q.push_back(24'h3002_00);
  endfunction

  task automatic setup(input int size, input int nacks);
    I_reg_size = 8'(size);
    nack_left  = nacks;
    obs_q.delete();
    obs_cyc.delete();
    build_exp(size, nacks);
  endtask

  task automatic pulse_start(input bit first);
    @(negedge I_clk);
    I_start = 1'b1;
    if (first) start_cyc = cyc;
    @(negedge I_clk);
    I_start = 1'b0;
    if (first) check("busy_rise", {31'h0, O_busy}, 32'h1);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(O_cfg_done || O_cfg_err) && n < BUDGET) begin
      @(negedge I_clk);
      n++;
    end
    check({tag, "_timeout"}, {31'h0, n < BUDGET}, 32'h1);
  endtask

  task automatic compare_run(input string tag, input bit timed);
    int n, gap, lat;
    n = obs_q.size();
    check({tag, "_nwr"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {8'h0, obs_q[i]}, {8'h0, exp_q[i]});
    check({tag, "_done"}, {31'h0, O_cfg_done}, {31'h0, !exp_err});
    check({tag, "_err"},  {31'h0, O_cfg_err},  {31'h0, exp_err});
    check({tag, "_busy"}, {31'h0, O_busy}, 32'h0);
    if (exp_err) begin
      check({tag, "_idx"}, {23'h0, O_reg_index}, exp_idx);
    end else if (n == exp_q.size() && n >= 2) begin
      gap = obs_cyc[n-1] - obs_cyc[n-2];
      check({tag, "_stby_lo"}, {31'h0, gap >= int'(STBY_DLY)},      32'h1);
      check({tag, "_stby_hi"}, {31'h0, gap <= int'(STBY_DLY) + 10}, 32'h1);
    end
    if (timed && n > 0) begin
      lat = obs_cyc[0] - start_cyc;
      check({tag, "_pwr_lo"}, {31'h0, lat > int'(PWRUP_DLY)},     32'h1);
      check({tag, "_pwr_hi"}, {31'h0, lat <= int'(PWRUP_DLY) + 5}, 32'h1);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_idx"},   {23'h0, O_reg_index}, 32'h0);
    check({tag, "_req"},   {31'h0, O_iic_req},   32'h0);
    check({tag, "_addr"},  {16'h0, O_iic_addr},  32'h0);
    check({tag, "_wdata"}, {24'h0, O_iic_wdata}, 32'h0);
    check({tag, "_busy"},  {31'h0, O_busy},      32'h0);
    check({tag, "_done"},  {31'h0, O_cfg_done},  32'h0);
    check({tag, "_err"},   {31'h0, O_cfg_err},   32'h0);
    check({tag, "_dev"},   {25'h0, O_iic_dev},   32'h1A);
  endtask

  initial begin
    int n;
    logic [31:0] r1, r2;
    for (int i = 0; i < 512; i++) begin
      r1 = $urandom();
      r2 = $urandom();
      lut[i] = {r1[31:24], 1'b1, r1[14:0], r2[7:0]};
    end
    lut[0][23:0]   = 24'h3000_01;
    lut[5][23:8]   = NACK_ADDR;
    lut[200][23:0] = 24'h4074_01;

    repeat (3) @(negedge I_clk);
    check_reset("rst");
    I_rst = 1'b0;

    // Full table, master acks everything.
    setup(201, 0);
    pulse_start(1'b1);
    wait_end("full");
    compare_run("full", 1'b1);

    // Master busy while the first entry waits in ISSUE.
    setup(8, 0);
    force_busy = 1'b1;
    pulse_start(1'b1);
    n = 0;
    repeat (60) begin
      @(negedge I_clk);
      if (O_iic_req) n++;
    end
    check("busy_noreq", n, 0);
    check("busy_hold", {8'h0, O_iic_addr, O_iic_wdata}, {8'h0, lut[0][23:0]});
    force_busy = 1'b0;
    @(negedge I_clk);
    check("busy_req", {31'h0, O_iic_req}, 32'h1);
    @(negedge I_clk);
    check("busy_pulse", {31'h0, O_iic_req}, 32'h0);
    wait_end("busy");
    compare_run("busy", 1'b0);

    // NACK past the retry allowance aborts at index 5.
    setup(10, TB_RETRIES + 1);
    pulse_start(1'b1);
    wait_end("nack");
    compare_run("nack", 1'b1);
    n = 0;
    repeat (30) begin
      @(negedge I_clk);
      if (O_iic_req) n++;
    end
    check("nack_quiet", n, 0);
`ifdef IMX415_CFG_RETRY_EN
    setup(10, TB_RETRIES - 1);
    pulse_start(1'b1);
    wait_end("retry");
    compare_run("retry", 1'b1);
`endif

    // Empty table: only standby release and XMSTA.
    setup(0, 0);
    pulse_start(1'b1);
    wait_end("empty");
    compare_run("empty", 1'b1);

    // Reset while waiting on entry 100; the late done must be ignored.
    setup(201, 0);
    fixed_lat = 4;
    pulse_start(1'b1);
    n = 0;
    while (!(O_iic_req && O_reg_index == 9'd100) && n < BUDGET) begin
      @(negedge I_clk);
      n++;
    end
    check("mid_reach", {31'h0, n < BUDGET}, 32'h1);
    I_rst = 1'b1;
    @(negedge I_clk);
    check_reset("mid_rst");
    I_rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge I_clk);
      if (O_iic_req || O_busy) n++;
    end
    check("mid_idle", n, 0);
    fixed_lat = 0;
    setup(201, 0);
    pulse_start(1'b1);
    wait_end("restart");
    compare_run("restart", 1'b1);

    // Start pulses during PWRUP and WAIT are ignored.
    setup(201, 0);
    pulse_start(1'b1);
    repeat (3) @(negedge I_clk);
    pulse_start(1'b0);
    n = 0;
    while (!(O_iic_req && O_reg_index == 9'd50) && n < BUDGET) begin
      @(negedge I_clk);
      n++;
    end
    check("ign_reach", {31'h0, n < BUDGET}, 32'h1);
    I_start = 1'b1;
    @(negedge I_clk);
    I_start = 1'b0;
    wait_end("ign");
    compare_run("ign", 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
